base_rom_scheduler: RTL and testbench
=====================================

# base_rom_scheduler

Time-multiplexes the single-port background tile ROM (1024 × 8-bit, 32×32 tiles scaled to 640×480) between the VGA scan-out and a game-logic tile query port. Tank collision and bullet logic use the query port to read the tile under a point. The scan-out path has absolute priority and uses a fixed prefetch schedule, so it consumes only one ROM slot per 20 pixels. All other cycles are free for queries. The block sits between the VGA controller, the tile ROM and the palette lookup.

## Interface
- H_TOTAL, 800: pixel clocks per line.
- H_ACTIVE, 640: visible pixels per line.
- V_TOTAL, 525: lines per frame.
- V_ACTIVE, 480: visible lines.
- TILE_W, 20: pixels per tile column.
- TILE_H, 15: lines per tile row.
- LINE_FETCH_X, 700: DrawX at which the first tile of the next line is fetched.
- vga_clk  in  1  pixel clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- DrawX  in  10  current pixel column, increments every vga_clk, wraps H_TOTAL-1→0.
- DrawY  in  10  current line, increments at the DrawX wrap, wraps V_TOTAL-1→0.
- rom_address  out  10  tile ROM address (row*32 + col).
- rom_q  in  8  ROM data, valid one cycle after its address is presented.
- pix_index  out  8  tile index for the pixel at DrawX/DrawY of the previous cycle.
- q_req  in  1  query request; held high with stable coordinates until q_ack.
- q_tile_x  in  5  query tile column.
- q_tile_y  in  5  query tile row.
- q_ack  out  1  one-cycle pulse; q_data is valid.
- q_data  out  8  tile index for the query, held until the next q_ack.

## Operation
- col = DrawX / TILE_W, sub = DrawX % TILE_W, row = DrawY / TILE_H. Any arithmetic form is allowed, but it must be exact for all inputs.
- Display slot (DS) is either of the following:
  - DrawX < H_ACTIVE, sub == 10 and col < 31: address = row*32 + col + 1 (next tile).
  - DrawX == LINE_FETCH_X and ny < V_ACTIVE, where ny = (DrawY == V_TOTAL-1) ? 0 : DrawY+1: address = (ny/TILE_H)*32.
- A 1-bit issuer tag is registered each cycle and marks which requester, if any, issued the read.
- The cycle after a DS, rom_q is captured into next_reg.
- cur_reg loads next_reg at the edge ending any cycle with DrawX < H_ACTIVE and sub == 0. pix_index = cur_reg.
- The query FSM has three states:
  - IDLE: if q_req and the cycle is not a DS, grant. rom_address = q_tile_y*32 + q_tile_x, go to WAIT. If the cycle is a DS, stay in IDLE; the request waits.
  - WAIT: capture rom_q into q_data, set q_ack, go to ACK.
  - ACK: q_ack is high for this cycle only, then go to IDLE. No grant is made in ACK.
- If q_req is still high in the IDLE cycle after ACK, it is a new request.
- When neither a DS nor a grant is active, rom_address = 0 and the tag is "none".
- A DS can never coincide with a query's WAIT capture, because a grant is never made in a DS cycle and DS cycles are at least 20 cycles apart.

## Timing
- Reset values: cur_reg, next_reg, q_data = 0; q_ack = 0; FSM = IDLE; tag = none; rom_address = 0.
- Display latency is 1 cycle. pix_index in cycle t+1 equals ROM[row*32+col] for DrawX/DrawY at cycle t, for all visible pixels.
- Display correctness begins with the first line after a DrawX == LINE_FETCH_X fetch that follows reset release. Before that, pix_index may be 0 or stale.
- Query latency, grant to q_ack high, is exactly 2 cycles. Best case from q_req rise is 2 cycles; if the request cycle is a DS, it is 3 cycles.
- Reset asserted mid-query: q_ack goes to 0 immediately, FSM returns to IDLE, and the query is dropped. The requester must re-request.
- Coordinate changes while q_req is held produce undefined q_data. This is a protocol violation.
- q_tile_x = 31, q_tile_y = 31 addresses ROM 1023. No other range check is applied.

## Test plan
- Scan with the ROM preloaded as addr mod 256, sweeping full frames. The cycle after DrawX = 0..19 on line 0, pix_index = 0; after DrawX = 20 it is 1; after DrawX = 620 on line 479 it is 1023 mod 256 = 255. There are zero mismatches over 2 frames.
- Single query (x=5, y=3) issued at a non-DS cycle -> grant in the same cycle, rom_address = 101, q_ack pulses 2 cycles later, q_data = 101.
- Query raised in the cycle with DrawX = 10 (a DS) -> rom_address = 1 (display) that cycle, grant on DrawX = 11, q_ack visible at DrawX = 13, and display output is unaffected.
- Back-to-back queries with q_req held continuously and coordinates changed after each ack -> one grant every 3 cycles, no duplicate q_ack, all q_data correct, with concurrent scan-out error-free.
- Frame wrap: DrawY 524 → 0 at DrawX = 700 fetches address 0. Line 479 → 480 performs no fetch; rom_address stays 0 unless a query is granted.
- reset_n pulsed low during WAIT -> q_ack stays 0, FSM is IDLE, and pix_index is correct from the next line onward after the next LINE_FETCH_X fetch.

Source files
------------

// File: rtl/base_rom_scheduler.sv
// rtl/base_rom_scheduler.sv - shares the tile ROM between VGA scan-out prefetch and a game-logic query port
module base_rom_scheduler #(
  parameter int H_ACTIVE     = 640,
  parameter int V_TOTAL      = 525,
  parameter int V_ACTIVE     = 480,
  parameter int TILE_W       = 20,
  parameter int TILE_H       = 15,
  parameter int LINE_FETCH_X = 700
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [9:0] rom_address,
  input  logic [7:0] rom_q,
  output logic [7:0] pix_index,
  input  logic       q_req,
  input  logic [4:0] q_tile_x,
  input  logic [4:0] q_tile_y,
  output logic       q_ack,
  output logic [7:0] q_data
);

  localparam logic [9:0] FETCH_SUB = 10'(TILE_W / 2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t     state, state_nxt;
  logic [9:0] col, sub, row, ny, ny_row, ds_addr;
  logic       ds_col, ds_line, ds, grant;
  logic       tag_vld, tag_qry;
  logic [7:0] next_reg, cur_reg;

  assign col    = DrawX / 10'(TILE_W);
  assign sub    = DrawX % 10'(TILE_W);
  assign row    = DrawY / 10'(TILE_H);
  assign ny     = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
  assign ny_row = ny / 10'(TILE_H);

  // Mid-tile fetch of the next column, plus the first tile of the next line during blanking.
  assign ds_col  = (DrawX < 10'(H_ACTIVE)) && (sub == FETCH_SUB) && (col < 10'd31);
  assign ds_line = (DrawX == 10'(LINE_FETCH_X)) && (ny < 10'(V_ACTIVE));
  assign ds      = reset_n && (ds_col || ds_line);
  assign ds_addr = ds_col ? (row << 5) + col + 10'd1 : (ny_row << 5);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (q_req && !ds) state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_ACK;
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    grant = reset_n && (state == S_IDLE) && q_req && !ds;
    q_ack = (state == S_ACK);
    if (ds)         rom_address = ds_addr;
    else if (grant) rom_address = {q_tile_y, q_tile_x};
    else            rom_address = 10'd0;
  end

  // The tag remembers who owned last cycle's read so rom_q lands in the right register.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_vld  <= 1'b0;
      tag_qry  <= 1'b0;
      next_reg <= 8'd0;
      cur_reg  <= 8'd0;
      q_data   <= 8'd0;
    end else begin
      tag_vld <= ds || grant;
      tag_qry <= grant;
      if (tag_vld && !tag_qry)
        next_reg <= rom_q;
      if (state == S_WAIT)
        q_data <= rom_q;
      if ((DrawX < 10'(H_ACTIVE)) && (sub == 10'd0))
        cur_reg <= next_reg;
    end
  end

  assign pix_index = cur_reg;

endmodule

// File: tb/tb_base_rom_scheduler.sv
// tb/tb_base_rom_scheduler.sv - randomized scoreboard bench for base_rom_scheduler
module tb_base_rom_scheduler;

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic [9:0] DrawX, DrawY;
  logic [9:0] rom_address;
  logic [7:0] rom_q;
  logic [7:0] pix_index;
  logic       q_req;
  logic [4:0] q_tile_x, q_tile_y;
  logic       q_ack;
  logic [7:0] q_data;

  base_rom_scheduler dut (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .rom_address(rom_address),
    .rom_q      (rom_q),
    .pix_index  (pix_index),
    .q_req      (q_req),
    .q_tile_x   (q_tile_x),
    .q_tile_y   (q_tile_y),
    .q_ack      (q_ack),
    .q_data     (q_data)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } exp_t;

  logic [7:0] rom [1024];
  exp_t       disp_q[$];
  exp_t       q_exp[$];

  int  tests = 0;
  int  fails = 0;
  int  cycle = 0;
  int  addr_lat = 0;
  bit  ack_seen = 0;
  bit  pending = 0;
  int  exp_grant = -10;
  int  exp_ack = -10;
  int  q_addr = 0;
  int  gap = 0;
  int  nq = 0;
  bit  rst_test_armed = 1;
  int  rst_hold = 3;
  bit  display_ok = 0;
  bit  done = 0;
  int  seg = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cycle=%0d x=%0d y=%0d got=%0d expected=%0d", name, cycle, DrawX, DrawY, act, exp);
    end
  endtask

  // Which display fetch (if any) the schedule places at pixel (x,y), and its ROM address.
  function automatic bit ds_model(input int x, input int y, output int a);
    int ny;
    a = 0;
    if (x < 640 && x % 20 == 10 && x / 20 < 31) begin
      a = ((y / 15) * 32 + x / 20 + 1) % 1024;
      return 1'b1;
    end
    ny = (y == 524) ? 0 : y + 1;
    if (x == 700 && ny < 480) begin
      a = (ny / 15) * 32;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic issue();
    int d;
    if ($urandom_range(0, 9) == 0) begin
      q_tile_x = 5'd31;
      q_tile_y = 5'd31;
    end else begin
      q_tile_x = 5'($urandom_range(0, 31));
      q_tile_y = 5'($urandom_range(0, 31));
    end
    q_addr    = int'(q_tile_y) * 32 + int'(q_tile_x);
    q_req     = 1'b1;
    pending   = 1'b1;
    exp_grant = ds_model(int'(DrawX), int'(DrawY), d) ? cycle + 1 : cycle;
    exp_ack   = exp_grant + 2;
    q_exp.push_back('{exp_ack, rom[q_addr]});
    nq++;
  endtask

  // Monitor: samples on the falling edge and pops scoreboard entries as outputs appear.
  initial begin
    int   da, exp_a;
    exp_t e;
    forever begin
      @(negedge vga_clk);
      addr_lat = int'(rom_address);
      if (!reset_n) begin
        check("rst_pix", int'(pix_index), 0);
        check("rst_ack", int'(q_ack), 0);
        check("rst_qdata", int'(q_data), 0);
        check("rst_addr", int'(rom_address), 0);
      end else begin
        if (ds_model(int'(DrawX), int'(DrawY), da))
          exp_a = da;
        else if (pending && q_req && cycle == exp_grant)
          exp_a = q_addr;
        else
          exp_a = 0;
        check("rom_addr", int'(rom_address), exp_a);
        if (disp_q.size() > 0 && disp_q[0].cyc == cycle) begin
          e = disp_q.pop_front();
          check("pix", int'(pix_index), int'(e.val));
        end
        if (q_ack) begin
          if (q_exp.size() == 0) begin
            check("q_spurious", 1, 0);
          end else begin
            e = q_exp.pop_front();
            check("q_data", int'(q_data), int'(e.val));
            check("q_ack_cycle", cycle, e.cyc);
          end
          ack_seen = 1'b1;
        end
      end
    end
  end

  // Stimulus: scan counter with line jumps, ROM model, query requester and reset pulses.
  initial begin
    int ny;
    for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom_range(0, 255));
    reset_n  = 1'b0;
    DrawX    = 10'd0;
    DrawY    = 10'd523;
    q_req    = 1'b0;
    q_tile_x = 5'd0;
    q_tile_y = 5'd0;
    rom_q    = 8'd0;
    while (!done) begin
      @(posedge vga_clk);
      #1;
      cycle++;
      rom_q = rom[addr_lat];

      if (DrawX == 10'd799) begin
        DrawX = 10'd0;
        DrawY = (DrawY == 10'd524) ? 10'd0 : DrawY + 10'd1;
        if (seg == 0 && DrawY == 10'd17) begin
          DrawY = 10'd476; seg = 1; display_ok = 0;
        end else if (seg == 1 && DrawY == 10'd483) begin
          DrawY = 10'd522; seg = 2; display_ok = 0;
        end else if (seg == 2 && DrawY == 10'd2) begin
          done = 1;
        end
      end else begin
        DrawX = DrawX + 10'd1;
      end
      if (cycle > 40000) begin
        check("watchdog", cycle, 40000);
        done = 1;
      end

      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) reset_n = 1'b1;
      end

      if (pending && ack_seen) begin
        ack_seen = 1'b0;
        pending  = 1'b0;
        if (reset_n && $urandom_range(0, 1) == 1)
          issue();
        else begin
          q_req = 1'b0;
          gap   = $urandom_range(0, 4);
        end
      end else if (pending && rst_test_armed && nq >= 20 && cycle == exp_grant + 1) begin
        reset_n        = 1'b0;
        rst_hold       = 2;
        rst_test_armed = 0;
        q_req          = 1'b0;
        pending        = 1'b0;
        void'(q_exp.pop_back());
        disp_q.delete();
        display_ok     = 0;
      end else if (pending && cycle > exp_ack + 3) begin
        check("q_timeout", cycle, exp_ack);
        q_req   = 1'b0;
        pending = 1'b0;
        q_exp.delete();
      end else if (!pending && reset_n) begin
        if (gap > 0) gap--;
        else if ($urandom_range(0, 2) == 0) issue();
      end

      ny = (DrawY == 10'd524) ? 0 : int'(DrawY) + 1;
      if (reset_n && DrawX == 10'd700 && ny < 480) display_ok = 1;
      if (display_ok && DrawX < 10'd640 && DrawY < 10'd480)
        disp_q.push_back('{cycle + 1, rom[(int'(DrawY) / 15) * 32 + int'(DrawX) / 20]});
    end
    repeat (4) @(posedge vga_clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
